dpic_mem_arbiter: RTL

//  Shares the single DPI-C simulation memory port between IFU (read-only) and LSU (read/write).

---
 rtl/dpic_mem_arb_pkg.sv | 32 +++
 rtl/dpic_mem_req_check.sv | 23 ++
 rtl/dpic_mem_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dpic_mem_arb_pkg.sv
// Shared types and helpers for the DPI-C memory port arbiter.
// Request state, owner encoding and the legal store-mask set.
package dpic_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    // Access size in bytes for a store mask; 0 marks an illegal mask.
    function automatic logic [3:0] size_from_mask(input logic [7:0] mask);
        case (mask)
            MASK_B:  return 4'd1;
            MASK_H:  return 4'd2;
            MASK_W:  return 4'd4;
            MASK_D:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/dpic_mem_req_check.sv
// Combinational request legality check: store mask must be one of the
// four contiguous masks and the address must be aligned to the access size.
module dpic_mem_req_check
    import dpic_mem_arb_pkg::*;
(
    input  logic       wen,
    input  logic [7:0] mask,
    input  logic [2:0] addr_lo,
    output logic       err
);

    logic [3:0] size;
    logic [2:0] align_mask;

    always_comb begin
        // Loads always fetch a full doubleword, so their mask is not consulted.
        size       = wen ? size_from_mask(mask) : 4'd8;
        // Size 8 wraps to 3'b111 here, which is exactly the alignment mask wanted.
        align_mask = size[2:0] - 3'd1;
        err        = (size == 4'd0) || ((addr_lo & align_mask) != 3'd0);
    end

endmodule

// File: rtl/dpic_mem_arbiter.sv
// Arbitrates the single DPI-C memory port between IFU and LSU, one request
// in flight at a time, with an exactly-one-cycle write strobe per store.
module dpic_mem_arbiter
    import dpic_mem_arb_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int LSU_STREAK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    output logic [63:0] ifu_resp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_req_addr,
    input  logic        lsu_req_wen,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    output logic [63:0] lsu_resp_data,
    output logic        lsu_resp_err,
    output logic        mem_rd_en,
    output logic [63:0] mem_rd_addr,
    input  logic [63:0] mem_rd_data,
    output logic        mem_we_en,
    output logic [63:0] mem_we_addr,
    output logic [63:0] mem_we_data,
    output logic [7:0]  mem_we_mask
);

    localparam int CTR_W    = $clog2(LATENCY + 1);
    localparam int STREAK_W = $clog2(LSU_STREAK + 1);

    state_t              state, state_nxt;
    owner_t              req_owner;
    logic [63:0]         req_addr;
    logic                req_wen;
    logic [63:0]         req_wdata;
    logic [7:0]          req_wmask;
    logic                req_err;
    logic [63:0]         resp_data;
    logic [CTR_W-1:0]    ctr;
    logic [STREAK_W-1:0] streak;

    logic        arb_open, force_ifu, ifu_grant, lsu_grant, any_grant, last_wait;
    logic [63:0] sel_addr;
    logic        sel_wen;
    logic [7:0]  sel_wmask;
    logic        sel_err;

    function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] s);
        return (s == STREAK_W'(LSU_STREAK)) ? s : s + STREAK_W'(1);
    endfunction

    // Arbitration: LSU has priority unless IFU has been starved for LSU_STREAK grants.
    assign arb_open      = (state == IDLE) && !reset;
    assign force_ifu     = (streak == STREAK_W'(LSU_STREAK)) && ifu_req_valid;
    assign lsu_req_ready = arb_open && !force_ifu;
    assign ifu_req_ready = arb_open && (!lsu_req_valid || force_ifu);
    assign ifu_grant     = ifu_req_valid && ifu_req_ready;
    assign lsu_grant     = lsu_req_valid && lsu_req_ready;
    assign any_grant     = ifu_grant || lsu_grant;
    assign last_wait     = (state == WAIT) && (ctr == '0);

    assign sel_addr  = lsu_grant ? lsu_req_addr  : ifu_req_addr;
    assign sel_wen   = lsu_grant ? lsu_req_wen   : 1'b0;
    assign sel_wmask = lsu_grant ? lsu_req_wmask : MASK_D;

    dpic_mem_req_check u_req_check (
        .wen     (sel_wen),
        .mask    (sel_wmask),
        .addr_lo (sel_addr[2:0]),
        .err     (sel_err)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        ifu_resp_valid = 1'b0;
        ifu_resp_data  = '0;
        lsu_resp_valid = 1'b0;
        lsu_resp_data  = '0;
        lsu_resp_err   = 1'b0;
        mem_rd_en      = 1'b0;
        mem_rd_addr    = '0;
        mem_we_en      = 1'b0;
        mem_we_addr    = '0;
        mem_we_data    = '0;
        mem_we_mask    = '0;
        // Everything is gated by reset so a reset landing mid-WAIT cannot leak a write.
        if (!reset) begin
            case (state)
                IDLE: if (any_grant) state_nxt = WAIT;
                WAIT: begin
                    if (!req_err && !req_wen) begin
                        mem_rd_en   = 1'b1;
                        mem_rd_addr = req_addr;
                    end
                    if (!req_err && req_wen && last_wait) begin
                        mem_we_en   = 1'b1;
                        mem_we_addr = req_addr;
                        mem_we_data = req_wdata;
                        mem_we_mask = req_wmask;
                    end
                    if (ctr == '0) state_nxt = RESP;
                end
                RESP: begin
                    if (req_owner == OWN_IFU) begin
                        ifu_resp_valid = 1'b1;
                        ifu_resp_data  = resp_data;
                    end else begin
                        lsu_resp_valid = 1'b1;
                        lsu_resp_data  = resp_data;
                        lsu_resp_err   = req_err;
                    end
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Control registers: latency countdown and IFU starvation streak.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctr    <= '0;
            streak <= '0;
        end else begin
            if (any_grant)
                ctr <= CTR_W'(LATENCY - 1);
            else if (state == WAIT && ctr != '0)
                ctr <= ctr - CTR_W'(1);

            if (ifu_grant || !ifu_req_valid)
                streak <= '0;
            else if (lsu_grant)
                streak <= sat_inc(streak);
        end
    end

    // Request/response data registers; outputs are gated by state, so no reset needed.
    always_ff @(posedge clock) begin
        if (any_grant) begin
            req_owner <= lsu_grant ? OWN_LSU : OWN_IFU;
            req_addr  <= sel_addr;
            req_wen   <= sel_wen;
            req_wdata <= lsu_req_wdata;
            req_wmask <= lsu_req_wmask;
            req_err   <= sel_err;
        end
        if (last_wait)
            resp_data <= (req_err || req_wen) ? 64'd0 : mem_rd_data;
    end

endmodule
